// File: rtl/clint_pkg.sv
// clint_pkg: register offsets, reset constants, FSM states and AXI channel types for the CLINT
package clint_pkg;

    localparam logic [15:0] MSIP_OFF     = 16'h0000;
    localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] MTIME_OFF    = 16'hBFF8;
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_e;

    typedef struct packed {
        logic [5:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
    } ax_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [5:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [5:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } clint_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } clint_resp_t;

    // Byte-wise merge of write data into a 64-bit register under wstrb
    function automatic logic [63:0] strb_merge(input logic [63:0] cur, input logic [63:0] wdata,
                                               input logic [7:0] strb);
        logic [63:0] res;
        for (int i = 0; i < 8; i++) res[i*8 +: 8] = strb[i] ? wdata[i*8 +: 8] : cur[i*8 +: 8];
        return res;
    endfunction

endpackage

// File: rtl/clint_rtc_tick.sv
// clint_rtc_tick: 2-flop synchronizer plus rising-edge detect turning rtc_i into single-cycle ticks
module clint_rtc_tick (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rtc_i,
    output logic tick_o
);

    logic [2:0] sync_q;

    // Two synchronizer stages followed by a history flop for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else sync_q <= {sync_q[1:0], rtc_i};
    end

    assign tick_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ara_clint_axi.sv
// ara_clint_axi: AXI4 CLINT (msip/mtimecmp/mtime) for up to 8 harts; ARA_CLINT_RTC_SYNC_EN selects a synchronized rtc_i edge as the tick
module ara_clint_axi
    import clint_pkg::*;
#(
    parameter int unsigned NrHarts      = 1,
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned AxiIdWidth   = 6,
    parameter type axi_req_t  = clint_pkg::clint_req_t,
    parameter type axi_resp_t = clint_pkg::clint_resp_t
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               rtc_i,
    input  axi_req_t           axi_req_i,
    output axi_resp_t          axi_resp_o,
    output logic [NrHarts-1:0] ipi_o,
    output logic [NrHarts-1:0] time_irq_o
);

    if (AxiDataWidth != 64 || AxiAddrWidth < 16 || NrHarts < 1 || NrHarts > 8) begin : g_bad_cfg
        $error("ara_clint_axi: unsupported parameter configuration");
    end

    state_e                state_q;
    logic [AxiIdWidth-1:0] id_q;
    logic [15:0]           addr_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_q;
    logic [1:0]            resp_q;
    logic [63:0]           rdata_q;
    logic [63:0]           mtime_q;
    logic [63:0]           mtimecmp_q [NrHarts];
    logic [NrHarts-1:0]    msip_q;
    logic [NrHarts-1:0]    irq_q;
    logic                  tick;
    logic [15:0]           rd_a;
    logic [63:0]           rd_data;
    logic                  rd_hit;
    logic [NrHarts-1:0]    wr_msip;
    logic [NrHarts-1:0]    wr_cmp;
    logic                  wr_mtime;
    logic                  wr_hit;
    logic                  wr_en;
    logic                  r_last;
    logic                  unused_ok;

`ifdef ARA_CLINT_RTC_SYNC_EN
    clint_rtc_tick u_rtc_tick (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .rtc_i  (rtc_i),
        .tick_o (tick)
    );
`else
    assign tick = rtc_i;
`endif

    assign rd_a      = axi_req_i.ar.addr[15:0];
    assign wr_hit    = wr_mtime | (|wr_msip) | (|wr_cmp);
    assign wr_en     = state_q == WDATA && axi_req_i.w_valid && len_q == 8'd0;
    assign r_last    = beat_q == len_q;
    assign ipi_o     = msip_q;
    assign time_irq_o = irq_q;
    assign unused_ok = ^{axi_req_i.aw.addr[63:16], axi_req_i.ar.addr[63:16], addr_q[1:0], rd_a[1:0]};

    // Address decode: write hits from the latched AW address, read data/hit from the live AR address
    always_comb begin
        wr_msip  = '0;
        wr_cmp   = '0;
        wr_mtime = addr_q[15:3] == MTIME_OFF[15:3];
        rd_hit   = rd_a[15:3] == MTIME_OFF[15:3];
        rd_data  = rd_hit ? mtime_q : '0;
        for (int h = 0; h < NrHarts; h++) begin
            wr_msip[h] = addr_q[15:2] == MSIP_OFF[15:2] + 14'(h);
            wr_cmp[h]  = addr_q[15:14] == MTIMECMP_OFF[15:14] && addr_q[13:3] == 11'(h);
            if (rd_a[15:2] == MSIP_OFF[15:2] + 14'(h)) begin
                rd_hit  = 1'b1;
                rd_data = rd_a[2] ? {31'b0, msip_q[h], 32'b0} : {63'b0, msip_q[h]};
            end
            if (rd_a[15:14] == MTIMECMP_OFF[15:14] && rd_a[13:3] == 11'(h)) begin
                rd_hit  = 1'b1;
                rd_data = mtimecmp_q[h];
            end
        end
    end

    // CLINT registers: byte-strobed writes, mtime tick (write wins), registered timer compare
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_q <= '0;
            msip_q  <= '0;
            irq_q   <= '0;
            for (int h = 0; h < NrHarts; h++) mtimecmp_q[h] <= MTIMECMP_RST;
        end else begin
            mtime_q <= (wr_en && wr_mtime) ? strb_merge(mtime_q, axi_req_i.w.data, axi_req_i.w.strb)
                                           : mtime_q + 64'(tick);
            for (int h = 0; h < NrHarts; h++) begin
                if (wr_en && wr_cmp[h])
                    mtimecmp_q[h] <= strb_merge(mtimecmp_q[h], axi_req_i.w.data, axi_req_i.w.strb);
                if (wr_en && wr_msip[h] && (addr_q[2] ? axi_req_i.w.strb[4] : axi_req_i.w.strb[0]))
                    msip_q[h] <= addr_q[2] ? axi_req_i.w.data[32] : axi_req_i.w.data[0];
                irq_q[h] <= mtime_q >= mtimecmp_q[h];
            end
        end
    end

    // Transaction FSM: one AXI transaction at a time, AW wins over AR in IDLE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            resp_q  <= RESP_OKAY;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (axi_req_i.aw_valid) begin
                        state_q <= WDATA;
                        id_q    <= axi_req_i.aw.id;
                        addr_q  <= axi_req_i.aw.addr[15:0];
                        len_q   <= axi_req_i.aw.len;
                    end else if (axi_req_i.ar_valid) begin
                        state_q <= RDATA;
                        id_q    <= axi_req_i.ar.id;
                        addr_q  <= rd_a;
                        len_q   <= axi_req_i.ar.len;
                        beat_q  <= '0;
                        rdata_q <= axi_req_i.ar.len == 8'd0 ? rd_data : '0;
                        resp_q  <= axi_req_i.ar.len != 8'd0 ? RESP_SLVERR : rd_hit ? RESP_OKAY : RESP_DECERR;
                    end
                end
                WDATA: begin
                    if (axi_req_i.w_valid && axi_req_i.w.last) begin
                        state_q <= WRESP;
                        resp_q  <= len_q != 8'd0 ? RESP_SLVERR : wr_hit ? RESP_OKAY : RESP_DECERR;
                    end
                end
                WRESP: if (axi_req_i.b_ready) state_q <= IDLE;
                RDATA: begin
                    if (axi_req_i.r_ready) begin
                        beat_q <= beat_q + 8'd1;
                        if (r_last) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake and response channel outputs decoded from the registered FSM state
    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = state_q == IDLE && axi_req_i.aw_valid;
        axi_resp_o.ar_ready = state_q == IDLE && !axi_req_i.aw_valid && axi_req_i.ar_valid;
        axi_resp_o.w_ready  = state_q == WDATA;
        axi_resp_o.b_valid  = state_q == WRESP;
        axi_resp_o.b.id     = id_q;
        axi_resp_o.b.resp   = resp_q;
        axi_resp_o.r_valid  = state_q == RDATA;
        axi_resp_o.r.id     = id_q;
        axi_resp_o.r.data   = rdata_q;
        axi_resp_o.r.resp   = resp_q;
        axi_resp_o.r.last   = r_last;
    end

endmodule

// File: tb/tb_ara_clint_axi.sv
// tb_ara_clint_axi: directed self-checking bench for the AXI CLINT
module tb_ara_clint_axi;
    import clint_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        rtc;
    clint_req_t  req;
    clint_resp_t resp;
    logic [0:0]  ipi;
    logic [0:0]  irq;

    int          n_chk;
    int          n_pass;
    logic [1:0]  b_resp_got;
    logic [5:0]  b_id_got;
    logic        ipi_after_w;
    logic [63:0] rd_data [4];
    logic [1:0]  rd_resp [4];
    logic        rd_last [4];
    logic [5:0]  rd_id;
    int          rd_beats;

    ara_clint_axi dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rtc_i      (rtc),
        .axi_req_i  (req),
        .axi_resp_o (resp),
        .ipi_o      (ipi),
        .time_irq_o (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic hs_sig(input int sel);
        return sel == 0 ? resp.aw_ready : sel == 1 ? resp.w_ready : sel == 2 ? resp.b_valid :
               sel == 3 ? resp.ar_ready : resp.r_valid;
    endfunction

    // called at a negedge right after driving; returns at negedge+1 with the signal high or timed out
    task automatic wait_hs(input int sel, input string tag);
        int n = 0;
        #1;
        while (!hs_sig(sel) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, 64'(hs_sig(sel)), 64'd1);
    endtask

    task automatic axi_write(input logic [15:0] addr, input logic [63:0] data, input logic [7:0] strb,
                             input logic [7:0] len, input logic [5:0] id, input bit tick_on_w,
                             input int b_delay);
        @(negedge clk);
        req.aw       = '{id: id, addr: 64'(addr), len: len};
        req.aw_valid = 1'b1;
        wait_hs(0, "aw_hs");
        @(negedge clk);
        req.aw_valid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            req.w       = '{data: data, strb: strb, last: (b == int'(len))};
            req.w_valid = 1'b1;
            if (tick_on_w) rtc = 1'b1;
            wait_hs(1, "w_hs");
            @(negedge clk);
            req.w_valid = 1'b0;
            if (tick_on_w) rtc = 1'b0;
        end
        ipi_after_w = ipi[0];
        for (int i = 0; i < b_delay; i++) begin
            #1;
            chk("b_hold_valid", 64'(resp.b_valid), 64'd1);
            chk("b_hold_id", 64'(resp.b.id), 64'(id));
            @(negedge clk);
        end
        req.b_ready = 1'b1;
        wait_hs(2, "b_hs");
        b_resp_got = resp.b.resp;
        b_id_got   = resp.b.id;
        @(negedge clk);
        req.b_ready = 1'b0;
    endtask

    task automatic axi_read(input logic [15:0] addr, input logic [7:0] len, input logic [5:0] id);
        @(negedge clk);
        req.ar       = '{id: id, addr: 64'(addr), len: len};
        req.ar_valid = 1'b1;
        wait_hs(3, "ar_hs");
        @(negedge clk);
        req.ar_valid = 1'b0;
        req.r_ready  = 1'b1;
        rd_beats     = 0;
        for (int b = 0; b <= int'(len) && b < 4; b++) begin
            wait_hs(4, "r_hs");
            rd_data[b] = resp.r.data;
            rd_resp[b] = resp.r.resp;
            rd_last[b] = resp.r.last;
            rd_id      = resp.r.id;
            rd_beats++;
            @(negedge clk);
        end
        req.r_ready = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        req    = '0;
        rtc    = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ipi", 64'(ipi), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_w_ready", 64'(resp.w_ready), 64'd0);
        chk("rst_b_valid", 64'(resp.b_valid), 64'd0);
        chk("rst_r_valid", 64'(resp.r_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        axi_read(16'h4000, 8'd0, 6'h11);
        chk("cmp_rst_data", rd_data[0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("cmp_rst_resp", 64'(rd_resp[0]), 64'(2'b00));
        chk("cmp_rst_last", 64'(rd_last[0]), 64'd1);
        chk("cmp_rst_id", 64'(rd_id), 64'h11);
        chk("ipi_idle", 64'(ipi), 64'd0);
        chk("irq_idle", 64'(irq), 64'd0);

        axi_write(16'h0000, 64'd1, 8'h0F, 8'd0, 6'h01, 1'b0, 0);
        chk("msip1_bresp", 64'(b_resp_got), 64'(2'b00));
        chk("msip1_ipi_next", 64'(ipi_after_w), 64'd1);
        axi_write(16'h0000, 64'd0, 8'h00, 8'd0, 6'h01, 1'b0, 0);
        chk("msip_nostrb_ipi", 64'(ipi), 64'd1);
        axi_write(16'h0000, 64'd0, 8'h0F, 8'd0, 6'h01, 1'b0, 0);
        chk("msip0_ipi", 64'(ipi), 64'd0);
        axi_write(16'h0000, 64'hFFFF_FFFF, 8'h0F, 8'd0, 6'h01, 1'b0, 0);
        axi_read(16'h0000, 8'd0, 6'h02);
        chk("msip_rd_bit0", rd_data[0], 64'd1);
        axi_write(16'h0004, 64'd1, 8'hF0, 8'd0, 6'h03, 1'b0, 0);
        chk("msip_h1_decerr", 64'(b_resp_got), 64'(2'b11));

        axi_write(16'h4000, 64'd5, 8'hFF, 8'd0, 6'h04, 1'b0, 0);
        axi_write(16'h4000, 64'h0000_0000_0000_AB00, 8'h02, 8'd0, 6'h04, 1'b0, 0);
        axi_read(16'h4000, 8'd0, 6'h05);
        chk("cmp_bytelane", rd_data[0], 64'hAB05);
        axi_read(16'h4008, 8'd0, 6'h05);
        chk("cmp_h1_decerr", 64'(rd_resp[0]), 64'(2'b11));
        axi_write(16'h4000, 64'd5, 8'hFF, 8'd0, 6'h04, 1'b0, 0);
        axi_write(16'hBFF8, 64'd0, 8'hFF, 8'd0, 6'h06, 1'b0, 0);
        chk("irq_below", 64'(irq), 64'd0);
        rtc = 1'b1;
        repeat (5) @(negedge clk);
        chk("irq_at_reach", 64'(irq), 64'd0);
        @(negedge clk);
        chk("irq_after_reach", 64'(irq), 64'd1);
        rtc = 1'b0;
        axi_write(16'h4000, 64'd100, 8'hFF, 8'd0, 6'h07, 1'b0, 0);
        chk("irq_cleared", 64'(irq), 64'd0);
        axi_read(16'hBFF8, 8'd0, 6'h08);
        chk("mtime_count", rd_data[0], 64'd6);

        axi_write(16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 8'd0, 6'h09, 1'b0, 0);
        rtc = 1'b1;
        @(negedge clk);
        rtc = 1'b0;
        axi_read(16'hBFF8, 8'd0, 6'h0A);
        chk("mtime_wrap", rd_data[0], 64'd0);
        axi_write(16'hBFF8, 64'd7, 8'hFF, 8'd0, 6'h0B, 1'b1, 0);
        axi_read(16'hBFF8, 8'd0, 6'h0C);
        chk("mtime_wr_beats_tick", rd_data[0], 64'd7);

        axi_write(16'h4000, 64'h1234, 8'hFF, 8'd3, 6'h2A, 1'b0, 0);
        chk("wburst_slverr", 64'(b_resp_got), 64'(2'b10));
        chk("wburst_bid", 64'(b_id_got), 64'h2A);
        axi_read(16'h4000, 8'd0, 6'h0D);
        chk("wburst_cmp_kept", rd_data[0], 64'd100);
        axi_read(16'h4000, 8'd1, 6'h0E);
        chk("rburst_beats", 64'(rd_beats), 64'd2);
        chk("rburst_d0", rd_data[0], 64'd0);
        chk("rburst_d1", rd_data[1], 64'd0);
        chk("rburst_resp0", 64'(rd_resp[0]), 64'(2'b10));
        chk("rburst_resp1", 64'(rd_resp[1]), 64'(2'b10));
        chk("rburst_last0", 64'(rd_last[0]), 64'd0);
        chk("rburst_last1", 64'(rd_last[1]), 64'd1);

        @(negedge clk);
        req.aw       = '{id: 6'h03, addr: 64'h0, len: 8'd0};
        req.ar       = '{id: 6'h04, addr: 64'h0, len: 8'd0};
        req.aw_valid = 1'b1;
        req.ar_valid = 1'b1;
        #1;
        chk("prio_aw_ready", 64'(resp.aw_ready), 64'd1);
        chk("prio_ar_blocked", 64'(resp.ar_ready), 64'd0);
        @(negedge clk);
        req.aw_valid = 1'b0;
        req.w        = '{data: 64'd0, strb: 8'h0F, last: 1'b1};
        req.w_valid  = 1'b1;
        #1;
        chk("prio_w_ready", 64'(resp.w_ready), 64'd1);
        chk("prio_ar_wdata", 64'(resp.ar_ready), 64'd0);
        @(negedge clk);
        req.w_valid = 1'b0;
        req.b_ready = 1'b1;
        #1;
        chk("prio_b_valid", 64'(resp.b_valid), 64'd1);
        chk("prio_b_id", 64'(resp.b.id), 64'h03);
        chk("prio_ar_wresp", 64'(resp.ar_ready), 64'd0);
        @(negedge clk);
        req.b_ready = 1'b0;
        #1;
        chk("prio_ar_ready", 64'(resp.ar_ready), 64'd1);
        @(negedge clk);
        req.ar_valid = 1'b0;
        req.r_ready  = 1'b1;
        #1;
        chk("prio_r_valid", 64'(resp.r_valid), 64'd1);
        chk("prio_r_data", resp.r.data, 64'd0);
        chk("prio_r_id", 64'(resp.r.id), 64'h04);
        @(negedge clk);
        req.r_ready = 1'b0;

        axi_read(16'h8000, 8'd0, 6'h12);
        chk("unmapped_rresp", 64'(rd_resp[0]), 64'(2'b11));
        chk("unmapped_rdata", rd_data[0], 64'd0);
        axi_write(16'h8000, 64'hDEAD, 8'hFF, 8'd0, 6'h13, 1'b0, 0);
        chk("unmapped_bresp", 64'(b_resp_got), 64'(2'b11));

        axi_write(16'h0000, 64'd1, 8'h0F, 8'd0, 6'h15, 1'b0, 10);
        chk("bhold_bresp", 64'(b_resp_got), 64'(2'b00));
        chk("bhold_ipi", 64'(ipi), 64'd1);

        @(negedge clk);
        req.aw       = '{id: 6'h16, addr: 64'h4000, len: 8'd0};
        req.aw_valid = 1'b1;
        wait_hs(0, "abort_aw_hs");
        @(negedge clk);
        req.aw_valid = 1'b0;
        #1;
        chk("abort_in_wdata", 64'(resp.w_ready), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_w_ready", 64'(resp.w_ready), 64'd0);
        chk("abort_ipi", 64'(ipi), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_b_valid", 64'(resp.b_valid), 64'd0);
        axi_read(16'h4000, 8'd0, 6'h17);
        chk("abort_cmp_rst", rd_data[0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("abort_resp", 64'(rd_resp[0]), 64'(2'b00));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
